pipeline_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV64 pipeline.
- Drives the IF/ID register's `IFIDWrite`/`flush` controls, PC enable, ID/EX and EX/MEM bubble/hold controls.
- Sources: load-use hazards, EX-stage taken branches, multi-cycle mul/div ops in EX, and instruction-memory not-ready.
- Also counts front-end stall cycles for performance monitoring.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_if.sv | 45 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by the controller, its interface and the hazard unit.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN,
    MD_BUSY
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MD_LATENCY_DEF = 4;

  function automatic int md_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

  localparam int MD_CNT_W = md_cnt_w(MD_LATENCY_DEF);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage control outputs between the
// pipeline datapath and its stall/flush controller.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic       idex_mem_read;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_use_rs1;
  logic       ifid_use_rs2;
  logic       branch_taken;
  logic       md_start;
  logic       imem_ready;

  logic       PCWrite;
  logic       IFIDWrite;
  logic       flush;
  logic       idex_bubble;
  logic       idex_hold;
  logic       exmem_bubble;

  modport master (
    input  idex_mem_read, idex_rd,
    input  ifid_rs1, ifid_rs2,
    input  ifid_use_rs1, ifid_use_rs2,
    input  branch_taken, md_start,
    input  imem_ready,
    output PCWrite, IFIDWrite, flush,
    output idex_bubble, idex_hold,
    output exmem_bubble
  );

  modport slave (
    output idex_mem_read, idex_rd,
    output ifid_rs1, ifid_rs2,
    output ifid_use_rs1, ifid_use_rs2,
    output branch_taken, md_start,
    output imem_ready,
    input  PCWrite, IFIDWrite, flush,
    input  idex_bubble, idex_hold,
    input  exmem_bubble
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use compare between ID/EX and IF/ID.
// Register x0 never produces a hazard.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  output logic       lu_o
);

  logic hit1;
  logic hit2;

  assign hit1 = use_rs1_i & (rs1_i == rd_i);
  assign hit2 = use_rs2_i & (rs2_i == rd_i);

  assign lu_o = mem_read_i
              & (rd_i != REG_ZERO)
              & (hit1 | hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline, with
// mul/div hold sequencing and a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.master  bus,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = md_cnt_w(MD_LATENCY);
  localparam logic MD_ON = (MD_LATENCY >= 2);

  ctrl_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              lu;
  logic              pc_wr;
  logic              ifid_wr;
  logic              flush;
  logic              bubble;
  logic              hold;
  logic              ex_bub;

  hazard_detect u_hazard (
    .mem_read_i (bus.idex_mem_read),
    .rd_i       (bus.idex_rd),
    .rs1_i      (bus.ifid_rs1),
    .rs2_i      (bus.ifid_rs2),
    .use_rs1_i  (bus.ifid_use_rs1),
    .use_rs2_i  (bus.ifid_use_rs2),
    .lu_o       (lu)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_wr   = 1'b0;
    ifid_wr = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    ex_bub  = 1'b0;
    if (!reset) begin
      state_d = RUN;
      cnt_d   = '0;
      flush   = 1'b1;
      bubble  = 1'b1;
      ex_bub  = 1'b1;
    end else if (state_q == MD_BUSY && cnt_q != '0) begin
      ifid_wr = 1'b1;
      hold    = 1'b1;
      ex_bub  = 1'b1;
      cnt_d   = cnt_q - 1'b1;
    end else begin
      // The releasing MD_BUSY cycle masks md_start.
      if (state_q == MD_BUSY) state_d = RUN;
      if (bus.branch_taken) begin
        pc_wr  = 1'b1;
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (MD_ON && bus.md_start
                   && state_q == RUN) begin
        ifid_wr = 1'b1;
        hold    = 1'b1;
        ex_bub  = 1'b1;
        cnt_d   = CW'(MD_LATENCY - 2);
        state_d = MD_BUSY;
      end else if (lu) begin
        ifid_wr = 1'b1;
        bubble  = 1'b1;
      end else if (!bus.imem_ready) begin
        flush = 1'b1;
      end else begin
        pc_wr = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_wr && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  assign bus.PCWrite      = pc_wr;
  assign bus.IFIDWrite    = ifid_wr;
  assign bus.flush        = flush;
  assign bus.idex_bubble  = bubble;
  assign bus.idex_hold    = hold;
  assign bus.exmem_bubble = ex_bub;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branch priority,
// mul/div hold, reset abort, fetch wait and counter saturation.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] st;
  int         n_chk;
  int         n_pass;
  int         exp_st;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .MD_LATENCY (4),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .stall_cycles (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.idex_mem_read = 1'b0;
    bus.idex_rd       = 5'd0;
    bus.ifid_rs1      = 5'd0;
    bus.ifid_rs2      = 5'd0;
    bus.ifid_use_rs1  = 1'b0;
    bus.ifid_use_rs2  = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.md_start      = 1'b0;
    bus.imem_ready    = 1'b1;
  endtask

  // {PCWrite, IFIDWrite, flush, bubble, hold, exmem_bubble}
  task automatic outs(input string tag, input logic [5:0] e);
    #1;
    chk(tag, {26'd0, bus.PCWrite, bus.IFIDWrite, bus.flush,
              bus.idex_bubble, bus.idex_hold,
              bus.exmem_bubble}, {26'd0, e});
  endtask

  task automatic cnt(input string tag);
    chk(tag, {28'd0, st}, exp_st);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    exp_st = 0;
    idle();
    reset = 1'b0;
    outs("rst_outs", 6'b001101);
    tick();
    tick();
    cnt("rst_cnt");
    reset = 1'b1;
    outs("run_idle", 6'b100000);

    bus.idex_mem_read = 1'b1;
    bus.idex_rd       = 5'd5;
    bus.ifid_rs2      = 5'd5;
    bus.ifid_use_rs2  = 1'b1;
    outs("lu_rs2", 6'b010100);
    tick();
    exp_st = 1;
    cnt("lu_cnt");
    bus.idex_mem_read = 1'b0;
    outs("lu_done", 6'b100000);
    tick();
    cnt("lu_done_cnt");

    bus.idex_mem_read = 1'b1;
    bus.idex_rd       = 5'd0;
    bus.ifid_rs2      = 5'd0;
    outs("lu_x0", 6'b100000);
    tick();
    cnt("lu_x0_cnt");

    bus.idex_rd      = 5'd7;
    bus.ifid_rs1     = 5'd7;
    bus.ifid_use_rs1 = 1'b1;
    bus.ifid_use_rs2 = 1'b0;
    outs("lu_rs1", 6'b010100);
    bus.ifid_use_rs1 = 1'b0;
    outs("lu_nouse", 6'b100000);
    tick();
    cnt("lu_nouse_cnt");

    bus.idex_rd       = 5'd5;
    bus.ifid_rs2      = 5'd5;
    bus.ifid_use_rs2  = 1'b1;
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    outs("br_prio", 6'b101100);
    tick();
    cnt("br_cnt");

    idle();
    bus.md_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c < 4) outs($sformatf("md_hold%0d", c), 6'b010011);
      else       outs("md_rel", 6'b100000);
      tick();
    end
    bus.md_start = 1'b0;
    exp_st = 4;
    cnt("md_cnt");

    bus.md_start = 1'b1;
    tick();
    tick();
    outs("md_busy2", 6'b010011);
    reset = 1'b0;
    outs("mid_rst_outs", 6'b001101);
    tick();
    exp_st = 0;
    cnt("mid_rst_cnt");
    reset        = 1'b1;
    bus.md_start = 1'b0;
    outs("post_rst", 6'b100000);
    tick();
    cnt("post_rst_cnt");

    bus.imem_ready = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      outs($sformatf("fetch%0d", c), 6'b001000);
      tick();
    end
    exp_st = 2;
    cnt("fetch_cnt");

    for (int c = 0; c < 13; c++) tick();
    exp_st = 15;
    cnt("sat_full");
    outs("sat_stall", 6'b001000);
    tick();
    cnt("sat_hold");
    bus.imem_ready = 1'b1;
    outs("sat_run", 6'b100000);
    tick();
    cnt("sat_run_cnt");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
